vending_machine_param: RTL and testbench

Parametrised vending-machine controller: accumulates credit from two coin inputs, issues a one-cycle vend pulse when credit reaches `PRICE`, and then returns any surplus as unit change tokens over a req/ack handshake. An optional cancel path refunds partial credit. The block sits between coin-acceptor front-end logic, which delivers one-cycle coin pulses, and the dispenser/change-hopper drivers.

---
 rtl/vending_machine_param_if.sv | 24 ++
 rtl/vending_machine_param.sv | 100 ++++++++++
 tb/tb_vending_machine_param.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/vending_machine_param_if.sv
// Coin, refund and change-hopper handshake bundle for vending_machine_param.
// The master side is the coin front-end and hopper driver; the slave side is the controller.
interface vending_machine_param_if #(
    parameter int W = 4
);
    logic         a;
    logic         b;
    logic         cancel;
    logic         change_ack;
    logic         vend;
    logic         change_req;
    logic         busy;
    logic [W-1:0] credit;

    modport master (
        output a, b, cancel, change_ack,
        input  vend, change_req, busy, credit
    );

    modport slave (
        input  a, b, cancel, change_ack,
        output vend, change_req, busy, credit
    );
endinterface

// File: rtl/vending_machine_param.sv
// Vending controller: collects coin credit, pulses vend at PRICE, returns surplus over req/ack.
// Optional refund-on-cancel path is enabled by defining VEND_CANCEL_EN.
module vending_machine_param #(
    parameter int PRICE = 3,
    parameter int VAL_A = 2,
    parameter int VAL_B = 1,
    parameter int W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    vending_machine_param_if.slave    bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam logic [W:0] PRICE_W = (W+1)'(PRICE);
    localparam logic [W:0] VAL_A_W = (W+1)'(VAL_A);
    localparam logic [W:0] VAL_B_W = (W+1)'(VAL_B);

    state_t       state, state_next;
    logic [W-1:0] credit, credit_next;
    logic [W:0]   add, sum;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        add = '0;
        if (bus.a)
            add = VAL_A_W;
        else if (bus.b)
            add = VAL_B_W;
        sum = {1'b0, credit} + add;
    end

    always_comb begin
        state_next  = state;
        credit_next = credit;
        case (state)
            COLLECT: begin
                if (sum >= PRICE_W) begin
                    credit_next = W'(sum - PRICE_W);
                    state_next  = VEND;
                end
`ifdef VEND_CANCEL_EN
                else if (bus.cancel && (sum != '0)) begin
                    credit_next = sum[W-1:0];
                    state_next  = CHANGE;
                end
`endif
                else begin
                    credit_next = sum[W-1:0];
                end
            end
            VEND: begin
                state_next = (credit != '0) ? CHANGE : COLLECT;
            end
            CHANGE: begin
                if (bus.change_ack) begin
                    // Last unit (or a defensive zero) closes the refund.
                    if (credit <= W'(1)) begin
                        credit_next = '0;
                        state_next  = COLLECT;
                    end else begin
                        credit_next = credit - W'(1);
                    end
                end
            end
            default: begin
                state_next  = COLLECT;
                credit_next = '0;
            end
        endcase
    end

`ifndef VEND_CANCEL_EN
    logic unused_cancel;
    assign unused_cancel = bus.cancel;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= COLLECT;
            credit <= '0;
        end else begin
            state  <= state_next;
            credit <= credit_next;
        end
    end

    // Outputs decode registered state only, so reset clears them without a clock.
    assign bus.vend       = (state == VEND);
    assign bus.change_req = (state == CHANGE);
    assign bus.busy       = (state != COLLECT);
    assign bus.credit     = credit;

endmodule

// File: tb/tb_vending_machine_param.sv
// Self-checking bench for vending_machine_param at default parameters (PRICE=3, VAL_A=2, VAL_B=1).
// Table-driven vectors feed a scoreboard queue that is popped and compared one cycle later.
module tb_vending_machine_param;

    logic clk;
    logic rst;

    vending_machine_param_if #(.W(4)) bus ();

    vending_machine_param #(
        .PRICE (3),
        .VAL_A (2),
        .VAL_B (1),
        .W     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       cancel;
        logic       ack;
        logic [3:0] credit;
        logic       vend;
        logic       req;
        logic       busy;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t exp_q[$];

    function automatic vec_t mk(input logic a, input logic b, input logic c, input logic k,
                                input int cr, input logic vd, input logic rq, input logic bs);
        vec_t v;
        v.a = a; v.b = b; v.cancel = c; v.ack = k;
        v.credit = 4'(cr); v.vend = vd; v.req = rq; v.busy = bs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, ".credit"}, 32'(bus.credit), 32'(e.credit));
        check({tag, ".vend"}, 32'(bus.vend), 32'(e.vend));
        check({tag, ".change_req"}, 32'(bus.change_req), 32'(e.req));
        check({tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
    endtask

    // Drive one vector for one edge; expectation is queued now and compared after the edge.
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        bus.a          = v.a;
        bus.b          = v.b;
        bus.cancel     = v.cancel;
        bus.change_ack = v.ack;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_outputs(tag, e);
    endtask

    vec_t tbl[20];

    initial begin
        //              a  b  c  k  cr vd rq bs
        // exact payment with coin B
        tbl[0]  = mk(0, 1, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 2, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 1, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        // overpay, ack held high (ignored in COLLECT)
        tbl[4]  = mk(1, 0, 0, 1, 2, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 1, 1, 1, 0, 1);
        tbl[6]  = mk(0, 0, 0, 1, 1, 0, 1, 1);
        tbl[7]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
        // backpressure: five stalled CHANGE cycles, b dropped
        tbl[8]  = mk(1, 0, 0, 0, 2, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 1, 1, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 1, 0, 1, 1);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 1, 1);
        tbl[12] = mk(0, 1, 0, 0, 1, 0, 1, 1);
        tbl[13] = mk(0, 0, 0, 0, 1, 0, 1, 1);
        tbl[14] = mk(0, 0, 0, 0, 1, 0, 1, 1);
        tbl[15] = mk(0, 0, 0, 1, 0, 0, 0, 0);
        // simultaneous coins: a wins; coin during VEND dropped
        tbl[16] = mk(1, 1, 0, 0, 2, 0, 0, 0);
        tbl[17] = mk(1, 1, 0, 0, 1, 1, 0, 1);
        tbl[18] = mk(0, 1, 0, 0, 1, 0, 1, 1);
        tbl[19] = mk(0, 0, 0, 1, 0, 0, 0, 0);

        rst            = 1'b1;
        bus.a          = 1'b0;
        bus.b          = 1'b0;
        bus.cancel     = 1'b0;
        bus.change_ack = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // cancel of a partial credit
        step("cancel.coin", mk(0, 1, 0, 0, 1, 0, 0, 0));
`ifdef VEND_CANCEL_EN
        step("cancel.req",  mk(0, 0, 1, 0, 1, 0, 1, 1));
        step("cancel.ack",  mk(0, 0, 0, 1, 0, 0, 0, 0));
`else
        step("cancel.ign",  mk(0, 0, 1, 0, 1, 0, 0, 0));
        step("cancel.b2",   mk(0, 1, 0, 0, 2, 0, 0, 0));
        step("cancel.b3",   mk(0, 1, 0, 0, 0, 1, 0, 1));
        step("cancel.idle", mk(0, 0, 0, 0, 0, 0, 0, 0));
`endif
        // cancel with no credit has no effect; cancel with a completing coin loses to vend
        step("cancel.zero", mk(0, 0, 1, 0, 0, 0, 0, 0));
        step("cvend.coin",  mk(0, 1, 0, 0, 1, 0, 0, 0));
        step("cvend.a",     mk(1, 0, 1, 0, 0, 1, 0, 1));
        step("cvend.done",  mk(0, 0, 1, 0, 0, 0, 0, 0));

        // asynchronous reset mid-CHANGE with credit 1 and ack low
        step("arst.a1",     mk(1, 0, 0, 0, 2, 0, 0, 0));
        step("arst.a2",     mk(1, 0, 0, 0, 1, 1, 0, 1));
        step("arst.stall",  mk(0, 0, 0, 0, 1, 0, 1, 1));
        #2;
        rst = 1'b1;
        #1;
        check_outputs("arst.async", mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        step("arst.resume", mk(0, 1, 0, 0, 1, 0, 0, 0));
        step("arst.idle",   mk(0, 0, 0, 0, 1, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
